sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Shares the single frame-buffer memory command port between the camera write path and the LCD read path. Each side requests 8-beat × 32-bit bursts (16 pixels). The arbiter chooses the side, issues the command, streams write beats or forwards read beats, and enforces a recovery gap between commands. It sits between the frame-buffer controller's load/store engines and the SDRAM/PSRAM controller, and runs on the memory-side clock.

## Interface
Parameters:
- ADDR_WIDTH, 21, memory word address width
- BURST_BEATS, 8, 32-bit beats per command
- GAP_CYCLES, 4, idle cycles enforced after each burst (≥1)
- RD_TIMEOUT, 64, cycles from read cmd_en to last beat before abort

Ports:
- clk  in  1  memory-side clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- init_done  in  1  memory initialised; no grants while low
- wr_req  in  1  writer holds a full burst
- wr_addr  in  ADDR_WIDTH  burst base address, stable while wr_req high
- wr_data_in  in  32  FWFT write data, current beat
- wr_grant  out  1  one-cycle pulse, write request accepted
- wr_data_rd  out  1  beat consumed this cycle, writer advances
- wr_done  out  1  one-cycle pulse after last beat
- rd_req  in  1  reader wants a burst
- rd_addr  in  ADDR_WIDTH  burst base address, stable while rd_req high
- rd_urgent  in  1  display queue near empty, forces read priority
- rd_grant  out  1  one-cycle pulse, read accepted
- rd_data_out  out  32  forwarded read beat
- rd_data_valid_out  out  1  rd_data_out valid
- rd_done  out  1  one-cycle pulse, read burst finished (or aborted)
- mem_cmd  out  1  1 = write, 0 = read
- mem_cmd_en  out  1  one-cycle command strobe
- mem_addr  out  ADDR_WIDTH  command address
- mem_wr_data  out  32  write beat
- mem_rd_data  in  32  read beat
- mem_rd_data_valid  in  1  read beat valid
- error  out  1  sticky; cleared only by reset

## Operation
- States: IDLE, WR_BURST, RD_WAIT, GAP.
- Reset: state IDLE, last_served = WRITE, all outputs 0, error 0.
- IDLE, init_done=1, priority order:
  - rd_req & rd_urgent → read.
  - Else both requesting → opposite of last_served.
  - Else the single requester.
  - No requester, or init_done=0 → stay in IDLE.
- Read chosen: next cycle mem_cmd_en=1, mem_cmd=0, mem_addr=rd_addr, rd_grant=1 → RD_WAIT; beat counter and timeout counter cleared; last_served=READ.
- Write chosen: next cycle enter WR_BURST; first WR_BURST cycle has mem_cmd_en=1, mem_cmd=1, mem_addr=wr_addr, wr_grant=1; last_served=WRITE.
- WR_BURST:
  - Lasts exactly BURST_BEATS cycles.
  - mem_wr_data = wr_data_in (combinational); wr_data_rd=1 every cycle.
  - The cycle after the last beat: wr_done=1, → GAP.
- RD_WAIT:
  - Each mem_rd_data_valid is registered to rd_data_out / rd_data_valid_out (1-cycle latency); beat count incremented.
  - When BURST_BEATS beats have been counted: rd_done pulses together with the last rd_data_valid_out, → GAP.
  - If the timeout counter reaches RD_TIMEOUT first: error=1, rd_done=1, → GAP; late beats are not forwarded.
- GAP: GAP_CYCLES cycles with no command, then IDLE. Requests held during GAP are evaluated in IDLE.
- mem_rd_data_valid outside RD_WAIT, or a (BURST_BEATS+1)-th beat: beat dropped, error=1.
- wr_req/rd_req dropping after grant does not abort the burst.

## Timing
- Minimum command spacing:
  - Write: 1 (decide) + BURST_BEATS + 1 (done) + GAP_CYCLES = 14 cycles at defaults.
  - Read: 1 + memory latency + BURST_BEATS + GAP_CYCLES.
- Request sampled at edge k → mem_cmd_en high in cycle k+1.
- rd_data_out lags mem_rd_data by exactly 1 cycle; beats may have bubbles.
- Timeout counter starts at the cmd_en cycle (count 0); abort when count = RD_TIMEOUT−1 without the final beat.
- Reset asserted mid-burst: all outputs 0 immediately, state IDLE; no wr_done/rd_done is issued for the burst.
- init_done falling mid-burst: the burst completes; it only blocks new grants.

## Test plan
- Write only, wr_addr=0x00100, beats 0xA0..0xA7 → one cmd_en with mem_cmd=1, addr 0x00100, mem_wr_data A0..A7 on 8 consecutive cycles, wr_done on the 9th cycle, next cmd no earlier than 4 idle cycles later.
- Read, memory returns 8 beats after 4 cycles with 1 bubble → rd_data_out equals the beats delayed by 1 cycle, rd_done coincides with the 8th valid, error=0.
- wr_req and rd_req held high, rd_urgent=0 → grants alternate R,W,R,W from reset (first tie to read); with rd_urgent=1 → four consecutive reads.
- Read with no returned data → after 64 cycles rd_done=1 and error=1; a stray valid in IDLE afterwards is not forwarded.
- Reset pulse during the 4th write beat → mem_cmd_en, wr_data_rd and wr_done all 0 and no command issued until after reset; init_done=0 with both requests high → no grant ever.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single memory command port between the camera write path and the
// LCD read path: one burst at a time, with a fixed recovery gap after every burst.
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH  = 21,
    parameter int BURST_BEATS = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int RD_TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data_in,
    output logic                  wr_grant,
    output logic                  wr_data_rd,
    output logic                  wr_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_urgent,
    output logic                  rd_grant,
    output logic [31:0]           rd_data_out,
    output logic                  rd_data_valid_out,
    output logic                  rd_done,
    output logic                  mem_cmd,
    output logic                  mem_cmd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wr_data,
    input  logic [31:0]           mem_rd_data,
    input  logic                  mem_rd_data_valid,
    output logic                  error
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_BURST = 2'd1;
    localparam logic [1:0] ST_RD_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP      = 2'd3;

    localparam int MAX_AB  = (BURST_BEATS > GAP_CYCLES) ? BURST_BEATS : GAP_CYCLES;
    localparam int CNT_MAX = (RD_TIMEOUT > MAX_AB) ? RD_TIMEOUT : MAX_AB;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(BURST_BEATS + 1);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  last_rd_q, last_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_done_q, rd_done_d;
    logic                  error_q, error_d;
    logic                  take_rd, take_wr, beat_last;
    logic                  in_wr, wr_beat;

    // cnt_q is the beat index in WR_BURST, the timeout count in RD_WAIT and the gap count in GAP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        last_rd_d  = last_rd_q;
        addr_d     = addr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_done_d  = 1'b0;
        error_d    = error_q;
        take_rd    = 1'b0;
        take_wr    = 1'b0;
        beat_last  = (beat_q == BW'(BURST_BEATS - 1));

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                beat_d = '0;
                if (init_done) begin
                    // Urgent reads win outright; a tie goes to whoever was not served last.
                    if (rd_req && (rd_urgent || !wr_req || !last_rd_q)) begin
                        take_rd = 1'b1;
                    end else begin
                        take_wr = wr_req;
                    end
                end
                if (take_rd) begin
                    state_d   = ST_RD_WAIT;
                    addr_d    = rd_addr;
                    last_rd_d = 1'b1;
                end else if (take_wr) begin
                    state_d   = ST_WR_BURST;
                    addr_d    = wr_addr;
                    last_rd_d = 1'b0;
                end
            end
            ST_WR_BURST: begin
                if (cnt_q == CW'(BURST_BEATS)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_rd_data_valid) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_rd_data;
                    beat_d     = beat_q + BW'(1);
                end
                if (mem_rd_data_valid && beat_last) begin
                    rd_done_d = 1'b1;
                    state_d   = ST_GAP;
                    cnt_d     = '0;
                end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
                    rd_done_d = 1'b1;
                    error_d   = 1'b1;
                    state_d   = ST_GAP;
                    cnt_d     = '0;
                end
            end
            default: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        // A beat nobody asked for is dropped and flagged.
        if (mem_rd_data_valid && (state_q != ST_RD_WAIT)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            last_rd_q  <= 1'b0;
            addr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            last_rd_q  <= last_rd_d;
            addr_q     <= addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_done_q  <= rd_done_d;
            error_q    <= error_d;
        end
    end

    assign in_wr   = (state_q == ST_WR_BURST);
    assign wr_beat = in_wr && (cnt_q < CW'(BURST_BEATS));

    assign mem_cmd_en        = (in_wr || (state_q == ST_RD_WAIT)) && (cnt_q == '0);
    assign mem_cmd           = in_wr;
    assign mem_addr          = addr_q;
    assign wr_grant          = in_wr && (cnt_q == '0);
    assign rd_grant          = (state_q == ST_RD_WAIT) && (cnt_q == '0);
    assign wr_data_rd        = wr_beat;
    assign wr_done           = in_wr && (cnt_q == CW'(BURST_BEATS));
    assign mem_wr_data       = wr_beat ? wr_data_in : '0;
    assign rd_data_out       = rd_data_q;
    assign rd_data_valid_out = rd_valid_q;
    assign rd_done           = rd_done_q;
    assign error             = error_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter: a timestamp-based transaction model predicts
// every output each cycle; directed scenarios pin the model with literal expectations.
module tb_sdram_port_arbiter;
    localparam int AW  = 21;
    localparam int BB  = 8;
    localparam int GAP = 4;
    localparam int TO  = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          init_done = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data_in = 32'hA0;
    logic          wr_grant, wr_data_rd, wr_done;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_urgent = 1'b0;
    logic          rd_grant;
    logic [31:0]   rd_data_out;
    logic          rd_data_valid_out, rd_done;
    logic          mem_cmd, mem_cmd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data = '0;
    logic          mem_rd_data_valid = 1'b0;
    logic          error;

    sdram_port_arbiter #(.ADDR_WIDTH(AW), .BURST_BEATS(BB), .GAP_CYCLES(GAP), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data_in(wr_data_in),
        .wr_grant(wr_grant), .wr_data_rd(wr_data_rd), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_urgent(rd_urgent),
        .rd_grant(rd_grant), .rd_data_out(rd_data_out), .rd_data_valid_out(rd_data_valid_out),
        .rd_done(rd_done), .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_rd_data_valid(mem_rd_data_valid), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Model: a transaction is described by its command cycle, its kind and the cycle it
    // frees the port; registered read outputs are predicted one cycle ahead.
    int            m_cmd_at = -1, m_free_at = 0, m_rd_end = -1, m_nbeats = 0, m_wr_idx = 0;
    bit            m_kind_rd = 1'b0, m_last_rd = 1'b0, m_err = 1'b0;
    bit            e_rvalid = 1'b0, e_rdone = 1'b0;
    logic [31:0]   e_rdata = '0;
    logic [AW-1:0] m_addr = '0;
    bit            act, rdw, x_cmd, x_wr, x_wdone, pick_rd, pick_wr;

    // Observation logs used by the stimulus and the literal checks.
    int            n_cmd = 0, rd_cmd_cnt = 0, rd_cmd_at = -1, n_rvalid = 0;
    int            wr_done_cyc = -1, rd_done_cyc = -1;
    bit            wr_take = 1'b0;
    bit            cmd_kind_log[$];
    int            cmd_cyc_log[$];
    logic [AW-1:0] cmd_addr_log[$];
    logic [31:0]   wbeat_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_cmd_at = -1; m_free_at = cyc + 1; m_rd_end = -1; m_last_rd = 1'b0;
                m_err = 1'b0; e_rvalid = 1'b0; e_rdone = 1'b0; e_rdata = '0; m_addr = '0;
            end
            act     = (m_cmd_at >= 0) && (cyc >= m_cmd_at) && (cyc < m_free_at);
            x_cmd   = act && (cyc == m_cmd_at);
            x_wr    = act && !m_kind_rd && ((cyc - m_cmd_at) < BB);
            x_wdone = act && !m_kind_rd && ((cyc - m_cmd_at) == BB);

            check("cmd_en", mem_cmd_en, x_cmd);
            check("wr_grant", wr_grant, x_cmd && !m_kind_rd);
            check("rd_grant", rd_grant, x_cmd && m_kind_rd);
            check("wr_data_rd", wr_data_rd, x_wr);
            check("wr_done", wr_done, x_wdone);
            check("rd_valid", rd_data_valid_out, e_rvalid);
            check("rd_done", rd_done, e_rdone);
            check("error", error, m_err);
            if (x_cmd) begin
                check("mem_cmd", mem_cmd, !m_kind_rd);
                check("mem_addr", mem_addr, m_addr);
            end
            if (x_wr) check("wr_data", mem_wr_data, 32'hA0 + 32'(m_wr_idx));
            if (e_rvalid) check("rd_data", rd_data_out, e_rdata);
            if (reset) begin
                check("rst_addr", mem_addr, 0);
                check("rst_rdata", rd_data_out, 0);
                check("rst_wdata", mem_wr_data, 0);
            end

            if (mem_cmd_en) begin
                n_cmd++;
                cmd_kind_log.push_back(!mem_cmd);
                cmd_cyc_log.push_back(cyc);
                cmd_addr_log.push_back(mem_addr);
                if (!mem_cmd) begin
                    rd_cmd_cnt++;
                    rd_cmd_at = cyc;
                end
            end
            if (wr_done) wr_done_cyc = cyc;
            if (rd_done) rd_done_cyc = cyc;
            if (rd_data_valid_out) n_rvalid++;
            if (wr_data_rd) wbeat_log.push_back(mem_wr_data);
            wr_take = wr_data_rd;

            if (!reset) begin
                e_rvalid = 1'b0;
                e_rdone  = 1'b0;
                rdw = act && m_kind_rd && (m_rd_end < 0);
                if (mem_rd_data_valid) begin
                    if (rdw) begin
                        e_rvalid = 1'b1;
                        e_rdata  = mem_rd_data;
                        m_nbeats++;
                        if (m_nbeats == BB) begin
                            e_rdone = 1'b1; m_rd_end = cyc; m_free_at = cyc + 1 + GAP;
                        end
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (rdw && (m_rd_end < 0) && (cyc - m_cmd_at == TO - 1)) begin
                    e_rdone = 1'b1; m_err = 1'b1; m_rd_end = cyc; m_free_at = cyc + 1 + GAP;
                end
                if (x_wr) m_wr_idx++;
                if ((cyc >= m_free_at) && init_done) begin
                    pick_rd = 1'b0;
                    pick_wr = 1'b0;
                    if (rd_req && rd_urgent) pick_rd = 1'b1;
                    else if (rd_req && wr_req) begin
                        pick_rd = !m_last_rd;
                        pick_wr = m_last_rd;
                    end
                    else if (rd_req) pick_rd = 1'b1;
                    else if (wr_req) pick_wr = 1'b1;
                    if (pick_rd) begin
                        m_cmd_at = cyc + 1; m_kind_rd = 1'b1; m_addr = rd_addr; m_last_rd = 1'b1;
                        m_free_at = 32'h7fff_ffff; m_rd_end = -1; m_nbeats = 0;
                    end else if (pick_wr) begin
                        m_cmd_at = cyc + 1; m_kind_rd = 1'b0; m_addr = wr_addr; m_last_rd = 1'b0;
                        m_free_at = cyc + 2 + BB + GAP;
                    end
                end
            end
            cyc++;
        end
    end

    // Environment: FWFT writer plus a memory that answers read commands.
    int wr_idx = 0;
    int mem_lat = 4, fixed_bubble = -1, stray_req = 0;
    bit mem_rand = 1'b0, mem_nodata = 1'b0, mem_rand_nodata = 1'b0;
    int seen_rd = 0, beats_left = 0, next_at = 0, beat_no = 0, stray_done = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_take) wr_idx++;
            wr_data_in = 32'hA0 + 32'(wr_idx);
            mem_rd_data_valid = 1'b0;
            if (reset) begin
                beats_left = 0;
                seen_rd = rd_cmd_cnt;
            end else begin
                if (rd_cmd_cnt != seen_rd) begin
                    seen_rd = rd_cmd_cnt;
                    if (!mem_nodata && !(mem_rand_nodata && $urandom_range(0, 7) == 0)) begin
                        beats_left = BB;
                        beat_no = 0;
                        next_at = rd_cmd_at + (mem_rand ? int'($urandom_range(1, 6)) : mem_lat);
                    end
                end
                if (beats_left > 0 && cyc >= next_at) begin
                    mem_rd_data_valid = 1'b1;
                    mem_rd_data = $urandom;
                    beats_left--;
                    beat_no++;
                    next_at = cyc + 1;
                    if (beat_no == fixed_bubble) next_at++;
                    if (mem_rand && $urandom_range(0, 3) == 0) next_at++;
                end else if (stray_req != stray_done) begin
                    mem_rd_data_valid = 1'b1;
                    mem_rd_data = $urandom;
                    stray_done++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cmds(input int target, input int budget);
        int t = 0;
        while (n_cmd < target && t < budget) begin
            tick(1);
            t++;
        end
        check("cmd_seen", n_cmd, target);
    endtask

    task automatic wait_rd_done(input int budget);
        int t = 0;
        while (rd_done_cyc < rd_cmd_at && t < budget) begin
            tick(1);
            t++;
        end
        check("rd_done_seen", rd_done_cyc >= rd_cmd_at, 1);
    endtask

    initial begin
        int base, saved;
        tick(3);
        reset = 1'b0;
        init_done = 1'b1;
        tick(2);

        // Single write, with a read queued during its burst to expose the spacing.
        base = n_cmd;
        wr_addr = 21'h00100;
        wr_req = 1'b1;
        wait_cmds(base + 1, 20);
        wr_req = 1'b0;
        rd_addr = 21'h1ABCD;
        rd_req = 1'b1;
        fixed_bubble = 3;
        check("t1_kind", cmd_kind_log[base], 0);
        check("t1_addr", cmd_addr_log[base], 21'h00100);
        wait_cmds(base + 2, 30);
        rd_req = 1'b0;
        for (int i = 0; i < BB; i++) check("t1_beat", wbeat_log[i], 32'hA0 + 32'(i));
        check("t1_done_lat", wr_done_cyc - cmd_cyc_log[base], BB);
        check("t1_spacing", cmd_cyc_log[base + 1] - cmd_cyc_log[base], 14);
        wait_rd_done(40);
        check("t2_done_lat", rd_done_cyc - rd_cmd_at, 13);
        check("t2_error", error, 0);
        fixed_bubble = -1;
        tick(10);

        // Tie-breaking from reset, then urgent reads.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        mem_lat = 3;
        wr_addr = 21'h0A5A5;
        rd_addr = 21'h15A5A;
        wr_req = 1'b1;
        rd_req = 1'b1;
        base = n_cmd;
        wait_cmds(base + 4, 160);
        rd_urgent = 1'b1;
        for (int i = 0; i < 4; i++) check("alt_kind", cmd_kind_log[base + i], (i % 2 == 0) ? 1 : 0);
        base = n_cmd;
        wait_cmds(base + 4, 160);
        for (int i = 0; i < 4; i++) check("urg_kind", cmd_kind_log[base + i], 1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        rd_urgent = 1'b0;
        tick(30);

        // Random traffic.
        mem_rand = 1'b1;
        mem_rand_nodata = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if (!wr_req && $urandom_range(0, 7) == 0) begin
                wr_addr = AW'($urandom());
                wr_req = 1'b1;
            end else if (wr_req && $urandom_range(0, 15) == 0) wr_req = 1'b0;
            if (!rd_req && $urandom_range(0, 7) == 0) begin
                rd_addr = AW'($urandom());
                rd_req = 1'b1;
            end else if (rd_req && $urandom_range(0, 15) == 0) rd_req = 1'b0;
            rd_urgent = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) init_done = !init_done;
            if ($urandom_range(0, 127) == 0) stray_req++;
            tick(1);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        rd_urgent = 1'b0;
        init_done = 1'b1;
        mem_rand = 1'b0;
        mem_rand_nodata = 1'b0;
        tick(100);

        // Read timeout, then a stray beat in IDLE.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        mem_nodata = 1'b1;
        rd_addr = 21'h00777;
        rd_req = 1'b1;
        base = n_cmd;
        wait_cmds(base + 1, 20);
        rd_req = 1'b0;
        wait_rd_done(80);
        check("to_lat", rd_done_cyc - rd_cmd_at, TO);
        tick(1);
        check("to_error", error, 1);
        tick(8);
        saved = n_rvalid;
        stray_req++;
        tick(4);
        check("stray_fwd", n_rvalid, saved);
        mem_nodata = 1'b0;

        // Reset during the fourth write beat.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        wr_addr = 21'h02222;
        wr_req = 1'b1;
        base = n_cmd;
        saved = wr_done_cyc;
        wait_cmds(base + 1, 20);
        tick(2);
        reset = 1'b1;
        #1;
        check("rst_cmd_en", mem_cmd_en, 0);
        check("rst_wr_rd", wr_data_rd, 0);
        check("rst_wr_done", wr_done, 0);
        tick(3);
        check("rst_no_cmd", n_cmd, base + 1);
        reset = 1'b0;
        wr_req = 1'b0;
        tick(20);
        check("rst_no_done", wr_done_cyc, saved);

        // init_done low blocks all grants.
        init_done = 1'b0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        base = n_cmd;
        tick(50);
        check("init_block", n_cmd, base);
        init_done = 1'b1;
        tick(5);
        check("init_release", n_cmd, base + 1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end
endmodule
